// File: rtl/rs_bank.sv
// Reservation-station bank: allocates dispatched instructions, wakes operands from the CDB,
// and issues the oldest fully-ready entry through a valid/ready handshake.
module rs_bank #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned CDB_PORTS   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [XLEN-1:0]                disp_opa,
    input  logic [XLEN-1:0]                disp_opb,
    input  logic                           disp_opa_valid,
    input  logic                           disp_opb_valid,
    input  logic [TAG_W-1:0]               disp_dest_tag,
    input  logic [CTRL_W-1:0]              disp_ctrl,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]      cdb_value,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [XLEN-1:0]                issue_opa,
    output logic [XLEN-1:0]                issue_opb,
    output logic [TAG_W-1:0]               issue_dest_tag,
    output logic [CTRL_W-1:0]              issue_ctrl,
    output logic [$clog2(NUM_ENTRIES):0]   free_count
);

    localparam int unsigned AGE_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = AGE_W + 1;

    logic [NUM_ENTRIES-1:0] in_use_q, opa_v_q, opb_v_q;
    logic [XLEN-1:0]        opa_q  [NUM_ENTRIES];
    logic [XLEN-1:0]        opb_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       dest_q [NUM_ENTRIES];
    logic [CTRL_W-1:0]      ctrl_q [NUM_ENTRIES];
    logic [AGE_W-1:0]       age_q  [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] opa_hit, opb_hit, ready, sel_oh, alloc_oh, survive;
    logic [XLEN-1:0]        opa_cdb [NUM_ENTRIES];
    logic [XLEN-1:0]        opb_cdb [NUM_ENTRIES];
    logic [AGE_W-1:0]       rank    [NUM_ENTRIES];
    logic                   disp_a_hit, disp_b_hit;
    logic [XLEN-1:0]        disp_a_cdb, disp_b_cdb;
    logic [AGE_W-1:0]       best_age;
    logic                   found, disp_fire, issue_fire;

    // CDB snoop; ports are scanned high-to-low so the lowest matching port wins.
    always_comb begin
        disp_a_hit = 1'b0;
        disp_b_hit = 1'b0;
        disp_a_cdb = '0;
        disp_b_cdb = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            opa_hit[i] = 1'b0;
            opb_hit[i] = 1'b0;
            opa_cdb[i] = '0;
            opb_cdb[i] = '0;
        end
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p]) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (cdb_tag[p*TAG_W +: TAG_W] == opa_q[i][TAG_W-1:0]) begin
                        opa_hit[i] = 1'b1;
                        opa_cdb[i] = cdb_value[p*XLEN +: XLEN];
                    end
                    if (cdb_tag[p*TAG_W +: TAG_W] == opb_q[i][TAG_W-1:0]) begin
                        opb_hit[i] = 1'b1;
                        opb_cdb[i] = cdb_value[p*XLEN +: XLEN];
                    end
                end
                if (cdb_tag[p*TAG_W +: TAG_W] == disp_opa[TAG_W-1:0]) begin
                    disp_a_hit = 1'b1;
                    disp_a_cdb = cdb_value[p*XLEN +: XLEN];
                end
                if (cdb_tag[p*TAG_W +: TAG_W] == disp_opb[TAG_W-1:0]) begin
                    disp_b_hit = 1'b1;
                    disp_b_cdb = cdb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Oldest-ready select, lowest-free allocate, free count.
    always_comb begin
        found      = 1'b0;
        best_age   = '0;
        sel_oh     = '0;
        alloc_oh   = '0;
        free_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = in_use_q[i] && opa_v_q[i] && opb_v_q[i];
            if (ready[i] && (!found || age_q[i] > best_age)) begin
                found     = 1'b1;
                best_age  = age_q[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
            if (!in_use_q[i]) begin
                free_count = free_count + CNT_W'(1);
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!in_use_q[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
        disp_ready  = |(~in_use_q);
        issue_valid = found;
        disp_fire   = disp_valid && disp_ready;
        issue_fire  = found && issue_ready;
    end

    // Ages are re-ranked among surviving entries each cycle so they stay dense and never wrap.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            survive[i] = in_use_q[i] && !(issue_fire && sel_oh[i]);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rank[i] = disp_fire ? AGE_W'(1) : '0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i && survive[j] && age_q[j] < age_q[i]) begin
                    rank[i] = rank[i] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        issue_opa      = '0;
        issue_opb      = '0;
        issue_dest_tag = '0;
        issue_ctrl     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                issue_opa      = issue_opa | opa_q[i];
                issue_opb      = issue_opb | opb_q[i];
                issue_dest_tag = issue_dest_tag | dest_q[i];
                issue_ctrl     = issue_ctrl | ctrl_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_use_q <= '0;
            opa_v_q  <= '0;
            opb_v_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                opa_q[i]  <= '0;
                opb_q[i]  <= '0;
                dest_q[i] <= '0;
                ctrl_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else if (squash) begin
            in_use_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= rank[i];
                if (in_use_q[i] && !opa_v_q[i] && opa_hit[i]) begin
                    opa_q[i]   <= opa_cdb[i];
                    opa_v_q[i] <= 1'b1;
                end
                if (in_use_q[i] && !opb_v_q[i] && opb_hit[i]) begin
                    opb_q[i]   <= opb_cdb[i];
                    opb_v_q[i] <= 1'b1;
                end
                if (issue_fire && sel_oh[i]) begin
                    in_use_q[i] <= 1'b0;
                end
                if (disp_fire && alloc_oh[i]) begin
                    in_use_q[i] <= 1'b1;
                    age_q[i]    <= '0;
                    dest_q[i]   <= disp_dest_tag;
                    ctrl_q[i]   <= disp_ctrl;
                    opa_q[i]    <= (!disp_opa_valid && disp_a_hit) ? disp_a_cdb : disp_opa;
                    opb_q[i]    <= (!disp_opb_valid && disp_b_hit) ? disp_b_cdb : disp_opb;
                    opa_v_q[i]  <= disp_opa_valid || disp_a_hit;
                    opb_v_q[i]  <= disp_opb_valid || disp_b_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed scenarios plus random traffic against a dispatch-order model.
module tb_rs_bank;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int XL = 32;
    localparam int CW = 16;
    localparam int P  = 2;

    logic            clock = 1'b0;
    logic            reset, squash, disp_valid, disp_ready;
    logic [XL-1:0]   disp_opa, disp_opb;
    logic            disp_opa_valid, disp_opb_valid;
    logic [TW-1:0]   disp_dest_tag;
    logic [CW-1:0]   disp_ctrl;
    logic [P-1:0]    cdb_valid;
    logic [P*TW-1:0] cdb_tag;
    logic [P*XL-1:0] cdb_value;
    logic            issue_valid, issue_ready;
    logic [XL-1:0]   issue_opa, issue_opb;
    logic [TW-1:0]   issue_dest_tag;
    logic [CW-1:0]   issue_ctrl;
    logic [2:0]      free_count;

    int checks = 0;
    int errors = 0;

    rs_bank #(.NUM_ENTRIES(N), .TAG_W(TW), .XLEN(XL), .CTRL_W(CW), .CDB_PORTS(P)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opa(disp_opa), .disp_opb(disp_opb),
        .disp_opa_valid(disp_opa_valid), .disp_opb_valid(disp_opb_valid),
        .disp_dest_tag(disp_dest_tag), .disp_ctrl(disp_ctrl),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_dest_tag(issue_dest_tag), .issue_ctrl(issue_ctrl),
        .free_count(free_count)
    );

    always #5 clock = ~clock;

    // Model: an unordered pool of entries, each stamped with its dispatch sequence number.
    bit            m_used [N];
    bit            m_av   [N];
    bit            m_bv   [N];
    logic [XL-1:0] m_a    [N];
    logic [XL-1:0] m_b    [N];
    logic [TW-1:0] m_dest [N];
    logic [CW-1:0] m_ctrl [N];
    int            m_seq  [N];
    int            seq_ctr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_pick();
        int k = -1;
        for (int i = 0; i < N; i++)
            if (m_used[i] && m_av[i] && m_bv[i] && (k < 0 || m_seq[i] < m_seq[k])) k = i;
        return k;
    endfunction

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_used[i]) c++;
        return c;
    endfunction

    function automatic bit cdb_lookup(input logic [TW-1:0] t, output logic [XL-1:0] v);
        v = '0;
        for (int p = 0; p < P; p++)
            if (cdb_valid[p] && cdb_tag[p*TW +: TW] == t) begin
                v = cdb_value[p*XL +: XL];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic check_outputs();
        int k = m_pick();
        chk("issue_valid", {63'd0, issue_valid}, {63'd0, k >= 0});
        chk("free_count", {61'd0, free_count}, 64'(m_free()));
        chk("disp_ready", {63'd0, disp_ready}, {63'd0, m_free() > 0});
        if (k >= 0) begin
            chk("issue_opa", {32'd0, issue_opa}, {32'd0, m_a[k]});
            chk("issue_opb", {32'd0, issue_opb}, {32'd0, m_b[k]});
            chk("issue_dest", {58'd0, issue_dest_tag}, {58'd0, m_dest[k]});
            chk("issue_ctrl", {48'd0, issue_ctrl}, {48'd0, m_ctrl[k]});
        end else begin
            chk("idle_data", {issue_opa, issue_opb ^ {16'd0, issue_ctrl}},
                {32'd0, 26'd0, issue_dest_tag});
        end
    endtask

    task automatic model_update();
        int k, slot, nfree;
        logic [XL-1:0] v;
        if (reset || squash) begin
            for (int i = 0; i < N; i++) m_used[i] = 1'b0;
            return;
        end
        k = m_pick();
        nfree = m_free();
        slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_used[i]) slot = i;
        for (int i = 0; i < N; i++) begin
            if (m_used[i] && !m_av[i] && cdb_lookup(m_a[i][TW-1:0], v)) begin
                m_a[i] = v; m_av[i] = 1'b1;
            end
            if (m_used[i] && !m_bv[i] && cdb_lookup(m_b[i][TW-1:0], v)) begin
                m_b[i] = v; m_bv[i] = 1'b1;
            end
        end
        if (issue_ready && k >= 0) m_used[k] = 1'b0;
        if (disp_valid && nfree > 0) begin
            m_used[slot] = 1'b1;
            m_dest[slot] = disp_dest_tag;
            m_ctrl[slot] = disp_ctrl;
            m_seq[slot]  = seq_ctr++;
            m_a[slot] = disp_opa; m_av[slot] = disp_opa_valid;
            m_b[slot] = disp_opb; m_bv[slot] = disp_opb_valid;
            if (!disp_opa_valid && cdb_lookup(disp_opa[TW-1:0], v)) begin
                m_a[slot] = v; m_av[slot] = 1'b1;
            end
            if (!disp_opb_valid && cdb_lookup(disp_opb[TW-1:0], v)) begin
                m_b[slot] = v; m_bv[slot] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; squash = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        disp_opa = '0; disp_opb = '0; disp_opa_valid = 1'b0; disp_opb_valid = 1'b0;
        disp_dest_tag = '0; disp_ctrl = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic drive_disp(input logic [XL-1:0] a, input bit av, input logic [XL-1:0] b,
                              input bit bv, input logic [TW-1:0] d, input logic [CW-1:0] c);
        disp_valid = 1'b1;
        disp_opa = a; disp_opa_valid = av;
        disp_opb = b; disp_opb_valid = bv;
        disp_dest_tag = d; disp_ctrl = c;
    endtask

    task automatic set_cdb(input int p, input logic [TW-1:0] t, input logic [XL-1:0] v);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*TW +: TW] = t;
        cdb_value[p*XL +: XL] = v;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        idle();
        chk("rst_free", {61'd0, free_count}, 64'd4);
        chk("rst_ready", {63'd0, disp_ready}, 64'd1);
        chk("rst_valid", {63'd0, issue_valid}, 64'd0);
        chk("rst_data", {issue_opa, issue_opb}, 64'd0);

        // Ready-at-dispatch instruction issues the next cycle.
        drive_disp(32'h0, 1, 32'h123, 1, 6'd1, 16'h0a0a);
        step(); idle();
        chk("t1_valid", {63'd0, issue_valid}, 64'd1);
        chk("t1_opb", {32'd0, issue_opb}, 64'h123);
        chk("t1_dest", {58'd0, issue_dest_tag}, 64'd1);
        chk("t1_free", {61'd0, free_count}, 64'd3);
        issue_ready = 1'b1;
        step(); idle();
        chk("t1_free_after", {61'd0, free_count}, 64'd4);

        // Wakeup is visible only the cycle after the broadcast.
        drive_disp(32'd2, 0, 32'd7, 1, 6'd3, 16'h0003);
        step(); idle();
        repeat (3) step();
        set_cdb(0, 6'd2, 32'hFFFF_FABC);
        chk("t2_bcast_cycle", {63'd0, issue_valid}, 64'd0);
        step(); idle();
        chk("t2_valid", {63'd0, issue_valid}, 64'd1);
        chk("t2_opa", {32'd0, issue_opa}, 64'hFFFF_FABC);
        issue_ready = 1'b1;
        step(); idle();

        // Dispatch-cycle bypass from the CDB.
        drive_disp(32'd1, 1, 32'd5, 0, 6'd4, 16'h0004);
        set_cdb(0, 6'd5, 32'hABC);
        step(); idle();
        chk("t3_valid", {63'd0, issue_valid}, 64'd1);
        chk("t3_opb", {32'd0, issue_opb}, 64'hABC);
        issue_ready = 1'b1;
        step(); idle();

        // Fill, drop an extra dispatch, drain in dispatch order.
        for (int d = 1; d <= 4; d++) begin
            drive_disp(32'(d), 1, 32'(d * 16), 1, 6'(d), 16'(d));
            step(); idle();
        end
        chk("t4_ready", {63'd0, disp_ready}, 64'd0);
        chk("t4_free", {61'd0, free_count}, 64'd0);
        drive_disp(32'd9, 1, 32'd9, 1, 6'd9, 16'd9);
        step(); idle();
        chk("t4_free_drop", {61'd0, free_count}, 64'd0);
        for (int d = 1; d <= 4; d++) begin
            issue_ready = 1'b1;
            chk("t4_order", {58'd0, issue_dest_tag}, 64'(d));
            step(); idle();
        end
        chk("t4_empty", {61'd0, free_count}, 64'd4);

        // Oldest ready, not oldest overall.
        drive_disp(32'd10, 0, 32'd1, 1, 6'd20, 16'h0020);
        step(); idle();
        drive_disp(32'd2, 1, 32'd3, 1, 6'd21, 16'h0021);
        step(); idle();
        set_cdb(0, 6'd10, 32'h55);
        issue_ready = 1'b1;
        chk("t5_first", {58'd0, issue_dest_tag}, 64'd21);
        step(); idle();
        issue_ready = 1'b1;
        chk("t5_second", {58'd0, issue_dest_tag}, 64'd20);
        chk("t5_opa", {32'd0, issue_opa}, 64'h55);
        step(); idle();

        // Squash beats a same-cycle dispatch.
        for (int d = 0; d < 3; d++) begin
            drive_disp(32'd1, 1, 32'd1, 1, 6'(30 + d), 16'd0);
            step(); idle();
        end
        chk("t6_free_pre", {61'd0, free_count}, 64'd1);
        drive_disp(32'd1, 1, 32'd1, 1, 6'd33, 16'd0);
        squash = 1'b1;
        step(); idle();
        chk("t6_free", {61'd0, free_count}, 64'd4);
        chk("t6_valid", {63'd0, issue_valid}, 64'd0);

        // Two operands woken by different ports in one cycle.
        drive_disp(32'd3, 0, 32'd4, 0, 6'd40, 16'h0040);
        step(); idle();
        set_cdb(0, 6'd3, 32'hAAAA);
        set_cdb(1, 6'd4, 32'hBBBB);
        chk("t7_bcast_cycle", {63'd0, issue_valid}, 64'd0);
        step(); idle();
        chk("t7_valid", {63'd0, issue_valid}, 64'd1);
        chk("t7_ops", {issue_opa, issue_opb}, {32'hAAAA, 32'hBBBB});
        issue_ready = 1'b1;
        step(); idle();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            idle();
            disp_valid = ($urandom % 3) != 0;
            disp_opa_valid = $urandom % 2;
            disp_opb_valid = $urandom % 2;
            disp_opa = disp_opa_valid ? $urandom : 32'($urandom_range(0, 7));
            disp_opb = disp_opb_valid ? $urandom : 32'($urandom_range(0, 7));
            disp_dest_tag = 6'($urandom);
            disp_ctrl = 16'($urandom);
            for (int p = 0; p < P; p++)
                if ($urandom % 2) set_cdb(p, 6'($urandom_range(0, 7)), $urandom);
            issue_ready = ($urandom % 4) != 0;
            squash = ($urandom % 50) == 0;
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
